// File: rtl/irq_sched_ctrl.sv
// irq_sched_ctrl: interrupt scheduler between peripheral request lines and the CPU.
// Captures rising edges as pending bits and picks the lowest-index enabled pending line.
// Runs a request / acknowledge / end-of-interrupt handshake with the CPU.
// Optional feature macro: IRQC_WDOG_EN adds a service-timeout watchdog with a sticky wdog_err flag.
module irq_sched_ctrl #(
  parameter int NUM_IRQ     = 8,
  parameter int VEC_W       = 3,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq_lines,
  input  logic [NUM_IRQ-1:0] irq_en,
  input  logic               irq_dis,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               cpu_irq,
  output logic [VEC_W-1:0]   irq_vec,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service,
  output logic               wdog_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Reject configurations where the vector cannot encode every line or the timeout is degenerate
  if (NUM_IRQ > (1 << VEC_W) || WDOG_CYCLES < 2) begin : g_cfg_check
    $error("irq_sched_ctrl: invalid NUM_IRQ/VEC_W/WDOG_CYCLES configuration");
  end

  state_t             state, state_n;
  logic [NUM_IRQ-1:0] line_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ready;
  logic [NUM_IRQ-1:0] pending_n;
  logic [VEC_W-1:0]   sel;
  logic [VEC_W-1:0]   vec_n;
  logic               cpu_irq_n;
  logic               in_service_n;
  logic               withdraw;

  assign rise     = irq_lines & ~line_q;
  assign ready    = pending & irq_en;
  assign withdraw = irq_dis | ~irq_en[irq_vec];

`ifdef IRQC_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WDOG_CYCLES - 1);

  logic [CNT_W-1:0] wdog_cnt;
  logic             wdog_err_n;

  // Service timer: held at zero outside SERVICE so it restarts on every entry
  always_ff @(posedge clk) begin
    if (rst || state != SERVICE) wdog_cnt <= '0;
    else                         wdog_cnt <= wdog_cnt + 1'b1;
  end
`else
  assign wdog_err = 1'b0;
`endif

  // Fixed priority encoder: the lowest-index enabled pending line wins
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (ready[i]) sel = VEC_W'(i);
    end
  end

  // Next-state and next-output logic of the handshake FSM, plus pending bookkeeping
  always_comb begin
    state_n      = state;
    vec_n        = irq_vec;
    cpu_irq_n    = cpu_irq;
    in_service_n = in_service;
    pending_n    = pending;
`ifdef IRQC_WDOG_EN
    wdog_err_n   = wdog_err;
`endif
    case (state)
      IDLE: begin
        if (!irq_dis && |ready) begin
          vec_n     = sel;
          cpu_irq_n = 1'b1;
          state_n   = REQ;
        end
      end
      REQ: begin
        if (withdraw) begin
          cpu_irq_n = 1'b0;
          state_n   = IDLE;
        end else if (irq_ack) begin
          pending_n[irq_vec] = 1'b0;
          cpu_irq_n          = 1'b0;
          in_service_n       = 1'b1;
          state_n            = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi) begin
          in_service_n = 1'b0;
          state_n      = IDLE;
        end
`ifdef IRQC_WDOG_EN
        else if (wdog_cnt == CNT_MAX) begin
          in_service_n = 1'b0;
          wdog_err_n   = 1'b1;
          state_n      = IDLE;
        end
`endif
      end
      default: begin
        cpu_irq_n    = 1'b0;
        in_service_n = 1'b0;
        state_n      = IDLE;
      end
    endcase
    // A fresh edge on the line being acknowledged re-arms it, so set is applied last
    pending_n = pending_n | rise;
  end

  // State register and registered outputs, all cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      line_q     <= '0;
      pending    <= '0;
      irq_vec    <= '0;
      cpu_irq    <= 1'b0;
      in_service <= 1'b0;
`ifdef IRQC_WDOG_EN
      wdog_err   <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      line_q     <= irq_lines;
      pending    <= pending_n;
      irq_vec    <= vec_n;
      cpu_irq    <= cpu_irq_n;
      in_service <= in_service_n;
`ifdef IRQC_WDOG_EN
      wdog_err   <= wdog_err_n;
`endif
    end
  end

endmodule

// File: tb/tb_irq_sched_ctrl.sv
// Testbench for irq_sched_ctrl: directed sequence with a queue of expected vectors.
// Expected vectors are queued in service order when request edges are driven and
// popped when the DUT raises cpu_irq. Watchdog steps are compiled with IRQC_WDOG_EN.
module tb_irq_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_lines;
  logic [7:0] irq_en;
  logic       irq_dis;
  logic       irq_ack;
  logic       eoi;
  logic       cpu_irq;
  logic [2:0] irq_vec;
  logic [7:0] pending;
  logic       in_service;
  logic       wdog_err;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int waits;

  irq_sched_ctrl #(
    .NUM_IRQ    (8),
    .VEC_W      (3),
    .WDOG_CYCLES(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_lines (irq_lines),
    .irq_en    (irq_en),
    .irq_dis   (irq_dis),
    .irq_ack   (irq_ack),
    .eoi       (eoi),
    .cpu_irq   (cpu_irq),
    .irq_vec   (irq_vec),
    .pending   (pending),
    .in_service(in_service),
    .wdog_err  (wdog_err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case a step never returns
  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] lines, input logic [7:0] en, input logic dis);
    irq_lines = lines;
    irq_en    = en;
    irq_dis   = dis;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for cpu_irq and compare the presented vector with the queue head
  task automatic wait_present(input string tag, output int n);
    int e;
    n = 0;
    while (cpu_irq !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checkOutput({tag, "_present"}, {31'b0, cpu_irq}, 32'd1);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_scoreboard: observed=vector %0d expected=empty queue", tag, irq_vec);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_vec"}, {29'b0, irq_vec}, e);
    end
  endtask

  task automatic finish_service(input string tag);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput({tag, "_insvc"}, {31'b0, in_service}, 32'd1);
    checkOutput({tag, "_irq_drop"}, {31'b0, cpu_irq}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    checkOutput({tag, "_eoi"}, {31'b0, in_service}, 32'd0);
    checkOutput({tag, "_idle_irq"}, {31'b0, cpu_irq}, 32'd0);
  endtask

  task automatic serve_one(input string tag);
    int n;
    wait_present(tag, n);
    finish_service(tag);
  endtask

  initial begin
    rst = 1'b1;
    irq_ack = 1'b0;
    eoi = 1'b0;
    applyStimulus(8'h00, 8'h00, 1'b0);
    tick();
    tick();
    checkOutput("rst_cpu_irq", {31'b0, cpu_irq}, 32'd0);
    checkOutput("rst_vec", {29'b0, irq_vec}, 32'd0);
    checkOutput("rst_pending", {24'b0, pending}, 32'd0);
    checkOutput("rst_insvc", {31'b0, in_service}, 32'd0);
    checkOutput("rst_wdog", {31'b0, wdog_err}, 32'd0);
    rst = 1'b0;

    // 1: single line 3, latency and full handshake
    applyStimulus(8'h08, 8'hFF, 1'b0);
    tick();
    checkOutput("t1_pending", {24'b0, pending}, 32'h08);
    checkOutput("t1_no_irq_yet", {31'b0, cpu_irq}, 32'd0);
    tick();
    exp_q.push_back(3);
    wait_present("t1", waits);
    checkOutput("t1_latency", waits, 32'd0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("t1_ack_pending", {24'b0, pending}, 32'h00);
    checkOutput("t1_ack_insvc", {31'b0, in_service}, 32'd1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    checkOutput("t1_eoi_insvc", {31'b0, in_service}, 32'd0);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();

    // 2: lines 5 and 1 together, priority order and one idle cycle between services
    applyStimulus(8'h22, 8'hFF, 1'b0);
    exp_q.push_back(1);
    exp_q.push_back(5);
    serve_one("t2a");
    wait_present("t2b", waits);
    checkOutput("t2_idle_gap", waits, 32'd1);
    finish_service("t2b");
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();

    // 3: masked request stays pending, then served once enabled
    applyStimulus(8'h04, 8'h00, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("t3_masked_pending", {24'b0, pending}, 32'h04);
    checkOutput("t3_masked_irq", {31'b0, cpu_irq}, 32'd0);
    applyStimulus(8'h04, 8'h04, 1'b0);
    exp_q.push_back(2);
    serve_one("t3");
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();

    // 4: withdraw in REQ, ack in the same cycle loses, ack/eoi outside their states ignored
    applyStimulus(8'h10, 8'hFF, 1'b0);
    tick();
    tick();
    checkOutput("t4_req_irq", {31'b0, cpu_irq}, 32'd1);
    checkOutput("t4_req_vec", {29'b0, irq_vec}, 32'd4);
    irq_dis = 1'b1;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("t4_withdraw_irq", {31'b0, cpu_irq}, 32'd0);
    checkOutput("t4_withdraw_insvc", {31'b0, in_service}, 32'd0);
    checkOutput("t4_withdraw_pending", {24'b0, pending}, 32'h10);
    checkOutput("t4_withdraw_vec", {29'b0, irq_vec}, 32'd4);
    tick();
    tick();
    checkOutput("t4_dis_no_irq", {31'b0, cpu_irq}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("t4_stray_ack_insvc", {31'b0, in_service}, 32'd0);
    checkOutput("t4_stray_ack_pending", {24'b0, pending}, 32'h10);
    irq_dis = 1'b0;
    exp_q.push_back(4);
    serve_one("t4");
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();

    // New edge on line 6 coinciding with its ack: it stays pending
    applyStimulus(8'h40, 8'hFF, 1'b0);
    tick();
    applyStimulus(8'h00, 8'hFF, 1'b0);
    exp_q.push_back(6);
    wait_present("tsw", waits);
    applyStimulus(8'h40, 8'hFF, 1'b0);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("tsw_set_wins", {24'b0, pending}, 32'h40);
    checkOutput("tsw_insvc", {31'b0, in_service}, 32'd1);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    exp_q.push_back(6);
    serve_one("tsw_again");
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();

    // All lines at once: strict index order
    applyStimulus(8'hFF, 8'hFF, 1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    for (int i = 0; i < 8; i++) serve_one($sformatf("tall%0d", i));
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();

    // 5: held level gives one service only, then reset in SERVICE
    applyStimulus(8'h01, 8'hFF, 1'b0);
    exp_q.push_back(0);
    serve_one("t5_hold");
    repeat (16) tick();
    checkOutput("t5_hold_irq", {31'b0, cpu_irq}, 32'd0);
    checkOutput("t5_hold_pending", {24'b0, pending}, 32'h00);
    applyStimulus(8'h80, 8'hFF, 1'b0);
    exp_q.push_back(7);
    wait_present("t5_rst", waits);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    checkOutput("t5_in_service", {31'b0, in_service}, 32'd1);
    applyStimulus(8'h00, 8'hFF, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("t5_rst_irq", {31'b0, cpu_irq}, 32'd0);
    checkOutput("t5_rst_vec", {29'b0, irq_vec}, 32'd0);
    checkOutput("t5_rst_pending", {24'b0, pending}, 32'h00);
    checkOutput("t5_rst_insvc", {31'b0, in_service}, 32'd0);
    checkOutput("t5_rst_wdog", {31'b0, wdog_err}, 32'd0);
    rst = 1'b0;
    tick();

    // 6: long stay in SERVICE without eoi
    applyStimulus(8'h08, 8'hFF, 1'b0);
    exp_q.push_back(3);
    wait_present("t6", waits);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
`ifdef IRQC_WDOG_EN
    repeat (15) tick();
    checkOutput("t6_before_timeout", {31'b0, in_service}, 32'd1);
    checkOutput("t6_no_err_yet", {31'b0, wdog_err}, 32'd0);
    tick();
    checkOutput("t6_timeout_insvc", {31'b0, in_service}, 32'd0);
    checkOutput("t6_timeout_err", {31'b0, wdog_err}, 32'd1);
    repeat (5) tick();
    checkOutput("t6_err_sticky", {31'b0, wdog_err}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_err_cleared", {31'b0, wdog_err}, 32'd0);
`else
    repeat (40) tick();
    checkOutput("t6_still_insvc", {31'b0, in_service}, 32'd1);
    checkOutput("t6_wdog_tied", {31'b0, wdog_err}, 32'd0);
    eoi = 1'b1;
    tick();
    eoi = 1'b0;
    checkOutput("t6_eoi", {31'b0, in_service}, 32'd0);
`endif
    applyStimulus(8'h00, 8'hFF, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
